// File: rtl/pix_seq_pkg.sv
// rtl/pix_seq_pkg.sv - shared types for the pixel stream sequencer
package pix_seq_pkg;

  localparam int PIX_W_DEF = 24;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } seq_state_t;

  typedef struct packed {
    logic sof;
    logic eol;
  } pix_tag_t;

endpackage

// File: rtl/pix_seq_fifo2.sv
// rtl/pix_seq_fifo2.sv - 2-entry FIFO with flush, occupancy, push+pop when full
module pix_seq_fifo2 #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic [1:0]   occ
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop   = pop && (occ != 2'd0);
  assign do_push  = push && ((occ != 2'd2) || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pixel_stream_sequencer.sv
// rtl/pixel_stream_sequencer.sv - frame sequencer for the RGB pattern source; PIX_SEQ_FRAME_CNT_EN adds frame_count
module pixel_stream_sequencer
  import pix_seq_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int PIX_W    = PIX_W_DEF,
  parameter int NFRM_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [NFRM_W-1:0] num_frames,
  output logic              busy,
  output logic              done,
  output logic              src_rst,
  output logic              src_en,
  input  logic [PIX_W-1:0]  src_pixel,
  output logic [PIX_W-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sof,
  output logic              m_eol
`ifdef PIX_SEQ_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_count
`endif
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int FW = PIX_W + 2;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  seq_state_t        state, state_nxt;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [NFRM_W-1:0] frames;
  logic [NFRM_W-1:0] nfrm;
  logic              inflight;
  pix_tag_t          inflight_tag;
  pix_tag_t          issue_tag;
  pix_tag_t          head_tag;
  logic [PIX_W-1:0]  head_pix;
  logic [FW-1:0]     fifo_out;
  logic [1:0]        occ;
  logic [1:0]        total_nxt;
  logic              pop;
  logic              push;
  logic              last_issue;
  logic              start_ok;

  assign start_ok  = (state == IDLE) && start && !abort;
  assign pop       = m_valid && m_ready;
  // entries that will be held after this edge: FIFO + arriving pixel - departing pixel
  assign total_nxt = occ + {1'b0, inflight} - {1'b0, pop};
  assign src_en    = (state == RUN) && (total_nxt < 2'd2);
  assign issue_tag = '{sof: (x == '0) && (y == '0), eol: (x == X_LAST)};
  assign last_issue = (x == X_LAST) && (y == Y_LAST) && (nfrm != '0) &&
                      (frames == nfrm - NFRM_W'(1));

  // the arriving pixel bypasses the FIFO when it is empty and accepted at once
  assign push = inflight && !(pop && (occ == 2'd0));

  pix_seq_fifo2 #(.W(FW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .push      (push),
    .push_data ({inflight_tag, src_pixel}),
    .pop       (pop),
    .pop_data  (fifo_out),
    .occ       (occ)
  );

  assign {head_tag, head_pix} = (occ != 2'd0) ? fifo_out : {inflight_tag, src_pixel};
  assign m_valid = (state != IDLE) && ((occ != 2'd0) || inflight);
  assign m_data  = m_valid ? head_pix : '0;
  assign m_sof   = m_valid && head_tag.sof;
  assign m_eol   = m_valid && head_tag.eol;
  assign busy    = (state != IDLE);
  assign src_rst = (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (src_en && last_issue) state_nxt = DRAIN;
      DRAIN:   if (total_nxt == 2'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      done         <= 1'b0;
      inflight     <= 1'b0;
      inflight_tag <= '0;
      x            <= '0;
      y            <= '0;
      frames       <= '0;
      nfrm         <= '0;
    end else begin
      state    <= state_nxt;
      done     <= (state == DRAIN) && (total_nxt == 2'd0) && !abort;
      inflight <= src_en && !abort;
      if (src_en) inflight_tag <= issue_tag;
      if (start_ok) begin
        nfrm   <= num_frames;
        x      <= '0;
        y      <= '0;
        frames <= '0;
      end else if (src_en) begin
        if (x == X_LAST) begin
          x <= '0;
          if (y == Y_LAST) begin
            y      <= '0;
            frames <= frames + NFRM_W'(1);
          end else begin
            y <= y + YW'(1);
          end
        end else begin
          x <= x + XW'(1);
        end
      end
    end
  end

`ifdef PIX_SEQ_FRAME_CNT_EN
  logic [YW-1:0] out_y;

  // counts frames on the output side, so only fully accepted frames are included
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      out_y       <= '0;
      frame_count <= '0;
    end else if (pop && head_tag.eol) begin
      if (out_y == Y_LAST) begin
        out_y       <= '0;
        frame_count <= frame_count + 16'd1;
      end else begin
        out_y <= out_y + YW'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pixel_stream_sequencer.sv
// tb/tb_pixel_stream_sequencer.sv - scoreboard bench for pixel_stream_sequencer
module tb_pixel_stream_sequencer;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int PW = 24;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [NW-1:0] num_frames;
  logic          busy;
  logic          done;
  logic          src_rst;
  logic          src_en;
  logic [PW-1:0] src_pixel = '0;
  logic [PW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_sof;
  logic          m_eol;
`ifdef PIX_SEQ_FRAME_CNT_EN
  logic [15:0]   frame_count;
`endif

  pixel_stream_sequencer #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(PW), .NFRM_W(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .num_frames (num_frames),
    .busy       (busy),
    .done       (done),
    .src_rst    (src_rst),
    .src_en     (src_en),
    .src_pixel  (src_pixel),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_sof      (m_sof),
    .m_eol      (m_eol)
`ifdef PIX_SEQ_FRAME_CNT_EN
    ,
    .frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // n-th pixel produced by a freshly reset pattern source
  function automatic logic [PW-1:0] gen(input int n);
    logic [7:0] r, g, b;
    r = 8'(n);
    g = 8'(32'h55 + 2 * n);
    b = 8'(32'hAA + 3 * n);
    return {r, g, b};
  endfunction

  int src_cnt = 0;
  always @(posedge clk) begin
    if (src_rst) src_cnt <= 0;
    else if (src_en) begin
      src_pixel <= gen(src_cnt);
      src_cnt   <= src_cnt + 1;
    end
  end

  typedef struct {
    logic [PW-1:0] d;
    logic          sof;
    logic          eol;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_run(input int nf);
    for (int i = 0; i < nf * H * V; i++)
      exp_q.push_back('{gen(i), (i % (H * V)) == 0, (i % H) == H - 1});
  endtask

  int            xfers = 0;
  int            dones = 0;
  int            xfer_cyc[$];
  int            done_cyc[$];
  logic [PW-1:0] xfer_data[$];
  logic          prev_stall = 1'b0;
  logic [PW-1:0] prev_d;
  logic          prev_sof, prev_eol;

  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      if (prev_stall) begin
        chk("hold_valid", {31'd0, m_valid}, 32'd1);
        chk("hold_data", m_data, prev_d);
        chk("hold_tags", {30'd0, m_sof, m_eol}, {30'd0, prev_sof, prev_eol});
      end
      if (m_valid && m_ready) begin
        xfers++;
        xfer_cyc.push_back(cyc);
        xfer_data.push_back(m_data);
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("pix_data", m_data, e.d);
          chk("pix_sof", {31'd0, m_sof}, {31'd0, e.sof});
          chk("pix_eol", {31'd0, m_eol}, {31'd0, e.eol});
        end
      end
      if (done) begin
        dones++;
        done_cyc.push_back(cyc);
        chk("done_with_pending", 32'(exp_q.size()), 32'd0);
      end
      prev_stall = m_valid && !m_ready && !abort;
      prev_d     = m_data;
      prev_sof   = m_sof;
      prev_eol   = m_eol;
    end
  end

  // 0: always ready, 1: random 50%, 2: held low
  int rmode = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom % 2);
        default: m_ready = 1'b0;
      endcase
    end
  end

  int s_cyc;
  task automatic start_run(input int nf);
    @(posedge clk);
    #1;
    num_frames = NW'(nf);
    start      = 1'b1;
    s_cyc      = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0 = dones;
    int n  = 0;
    while (dones == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(name, {31'd0, dones > d0}, 32'd1);
  endtask

  task automatic clear_logs();
    xfer_cyc.delete();
    done_cyc.delete();
    xfer_data.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, x0, n, en_late;
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    num_frames = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_src_rst", {31'd0, src_rst}, 32'd1);
    chk("rst_src_en", {31'd0, src_en}, 32'd0);
    chk("rst_valid_tags", {29'd0, m_valid, m_sof, m_eol}, 32'd0);
    chk("rst_data", m_data, 24'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // single frame, timing
    clear_logs();
    d0 = dones;
    push_run(1);
    start_run(1);
    wait_done(100, "t1_done_seen");
    chk("t1_xfers", 32'(xfer_cyc.size()), 32'd8);
    chk("t1_first_cyc", 32'(xfer_cyc.size() > 0 ? xfer_cyc[0] - s_cyc : -1), 32'd2);
    chk("t1_last_cyc", 32'(xfer_cyc.size() > 0 ? xfer_cyc[xfer_cyc.size()-1] - s_cyc : -1), 32'd9);
    chk("t1_done_cyc", 32'(done_cyc.size() > 0 ? done_cyc[0] - s_cyc : -1), 32'd10);
    #1;
    chk("t1_busy_after", {31'd0, busy}, 32'd0);
    chk("t1_src_rst_after", {31'd0, src_rst}, 32'd1);
    repeat (5) @(posedge clk);
    chk("t1_done_count", 32'(dones - d0), 32'd1);

    // three frames back to back
    clear_logs();
    d0 = dones;
    push_run(3);
    start_run(3);
    wait_done(200, "t2_done_seen");
    repeat (10) @(posedge clk);
    chk("t2_xfers", 32'(xfer_cyc.size()), 32'd24);
    chk("t2_contiguous", 32'(xfer_cyc.size() == 24 ? xfer_cyc[23] - xfer_cyc[0] : -1), 32'd23);
    chk("t2_done_count", 32'(dones - d0), 32'd1);
    chk("t2_done_after_last",
        32'(done_cyc.size() > 0 && xfer_cyc.size() > 0 ? done_cyc[0] - xfer_cyc[xfer_cyc.size()-1] : -1), 32'd1);

    // random backpressure
    d0    = dones;
    rmode = 1;
    push_run(2);
    start_run(2);
    wait_done(600, "t3_done_seen");
    rmode = 0;
    repeat (3) @(posedge clk);
    chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("t3_done_count", 32'(dones - d0), 32'd1);

    // long stall mid-line
    clear_logs();
    push_run(3);
    start_run(3);
    repeat (4) @(posedge clk);
    #1;
    rmode   = 2;
    en_late = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i >= 4 && src_en) en_late++;
    end
    chk("t4_src_en_stopped", 32'(en_late), 32'd0);
    chk("t4_valid_in_stall", {31'd0, m_valid}, 32'd1);
    rmode = 0;
    n     = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i >= 2 && m_valid && m_ready) n++;
    end
    chk("t4_no_gap_resume", 32'(n), 32'd10);
    wait_done(200, "t4_done_seen");
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // abort with FIFO full, then restart
    rmode = 2;
    repeat (2) @(posedge clk);
    d0 = dones;
    push_run(1);
    start_run(1);
    repeat (6) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_valid", {31'd0, m_valid}, 32'd0);
    chk("t5_src_rst", {31'd0, src_rst}, 32'd1);
    exp_q.delete();
    repeat (5) @(posedge clk);
    chk("t5_no_done", 32'(dones - d0), 32'd0);
    rmode = 0;
    clear_logs();
    push_run(1);
    start_run(1);
    wait_done(100, "t5_restart_done");
    chk("t5_restart_first", xfer_data.size() > 0 ? 32'(xfer_data[0]) : 32'hFFFFFFFF, 32'h0055AA);

    // continuous mode, ignored start, abort
    d0    = dones;
    x0    = xfers;
    rmode = 1;
    push_run(7);
    start_run(0);
    n = 0;
    while (xfers < x0 + 10 && n < 400) begin @(posedge clk); n++; end
    #1;
    num_frames = 8'd1;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("t6_start_ignored_busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (xfers < x0 + 5 * H * V && n < 1000) begin @(posedge clk); n++; end
    chk("t6_five_frames", {31'd0, xfers >= x0 + 5 * H * V}, 32'd1);
    chk("t6_still_busy", {31'd0, busy}, 32'd1);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    exp_q.delete();
    chk("t6_abort_idle", {31'd0, busy}, 32'd0);
    chk("t6_no_done", 32'(dones - d0), 32'd0);
    rmode = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("t6_start_abort_busy", {31'd0, busy}, 32'd0);
    chk("t6_start_abort_valid", {31'd0, m_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_stays_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
